// File: rtl/mbc_bus_sequencer_if.sv
// Cartridge-side bus bundle for mbc_bus_sequencer.
// master: GB bus / host loader driving the sequencer. slave: the sequencer itself.
interface mbc_bus_sequencer_if;
  logic       gb_write_n;
  logic       gb_read_n;
  logic [2:0] gb_addr;
  logic [4:0] gb_data;
  logic       host_req;
  logic       host_gnt;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [4:0] cfg_data;
  logic       busy;

  modport master (
    output gb_write_n, gb_read_n, gb_addr, gb_data, host_req,
    input  host_gnt, cfg_we, cfg_sel, cfg_data, busy
  );

  modport slave (
    input  gb_write_n, gb_read_n, gb_addr, gb_data, host_req,
    output host_gnt, cfg_we, cfg_sel, cfg_data, busy
  );
endinterface

// File: rtl/mbc_bus_sequencer.sv
// mbc_bus_sequencer: synchronizes the async GB cartridge bus, qualifies ROM-region
// write strobes over a settle window and issues one cfg_we pulse per valid write.
// Grants the cart memory to the host loader after the GB bus has been quiet.
// Optional: define MBC_GLITCH_CNT_EN to add the glitch_cnt[7:0] abort counter port.
module mbc_bus_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 3,
  parameter int unsigned HOST_IDLE   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mbc_bus_sequencer_if.slave   bus
`ifdef MBC_GLITCH_CNT_EN
  ,
  output logic [7:0]           glitch_cnt
`endif
);

  localparam logic [3:0] SETTLE_C    = 4'(SETTLE);
  localparam logic [7:0] HOST_IDLE_C = 8'(HOST_IDLE);

  // Packed bus word: {wr_n, rd_n, addr[2:0], data[4:0]}; reset value is bus-idle.
  localparam logic [9:0] BUS_IDLE = {1'b1, 1'b1, 3'b000, 5'b00000};

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    COMMIT,
    WAIT_HI,
    HOST
  } state_t;

  logic [9:0] sync_q [SYNC_STAGES];
  logic [9:0] bus_raw;
  logic       s_wr_n;
  logic       s_rd_n;
  logic [2:0] s_addr;
  logic [4:0] s_data;
  logic       s_quiet;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] idle_cnt;
  logic       cfg_we_q;
  logic [1:0] cfg_sel_q;
  logic [4:0] cfg_data_q;
  logic       host_gnt_q;
  logic       busy_q;

  assign bus_raw = {bus.gb_write_n, bus.gb_read_n, bus.gb_addr, bus.gb_data};

  // Synchronizer chain for every gb_* input.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= BUS_IDLE;
      end
    end else begin
      sync_q[0] <= bus_raw;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s_wr_n  = sync_q[SYNC_STAGES-1][9];
  assign s_rd_n  = sync_q[SYNC_STAGES-1][8];
  assign s_addr  = sync_q[SYNC_STAGES-1][7:5];
  assign s_data  = sync_q[SYNC_STAGES-1][4:0];
  assign s_quiet = s_wr_n & s_rd_n;

  // Quiet-bus counter gating the host grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!s_quiet) begin
      idle_cnt <= '0;
    end else if (idle_cnt < HOST_IDLE_C) begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  // Write-qualification / host-grant FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      cfg_we_q   <= 1'b0;
      cfg_sel_q  <= '0;
      cfg_data_q <= '0;
      host_gnt_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef MBC_GLITCH_CNT_EN
      glitch_cnt <= '0;
`endif
    end else begin
      cfg_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!s_wr_n && !s_addr[2]) begin
            state  <= SAMPLE;
            cnt    <= 4'd1;
            busy_q <= 1'b1;
          end else if (!s_wr_n) begin
            state  <= WAIT_HI;
            busy_q <= 1'b1;
          end else if (bus.host_req && (idle_cnt >= HOST_IDLE_C)) begin
            state      <= HOST;
            host_gnt_q <= 1'b1;
          end
        end
        SAMPLE: begin
          if (s_wr_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
`ifdef MBC_GLITCH_CNT_EN
            if (glitch_cnt != 8'hFF) begin
              glitch_cnt <= glitch_cnt + 8'd1;
            end
`endif
          end else if (cnt == SETTLE_C) begin
            state      <= COMMIT;
            cfg_we_q   <= 1'b1;
            cfg_sel_q  <= s_addr[1:0];
            cfg_data_q <= s_data;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        COMMIT: begin
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (s_wr_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        HOST: begin
          if (!bus.host_req || !s_rd_n || !s_wr_n) begin
            state      <= IDLE;
            host_gnt_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          host_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_we   = cfg_we_q;
  assign bus.cfg_sel  = cfg_sel_q;
  assign bus.cfg_data = cfg_data_q;
  assign bus.host_gnt = host_gnt_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mbc_bus_sequencer.sv
// Testbench for mbc_bus_sequencer: directed scenarios plus randomized write
// transactions checked against a transaction-level timing model.
module tb_mbc_bus_sequencer;

  localparam int SYNC      = 2;
  localparam int SETTLE    = 3;
  localparam int HOST_IDLE = 16;
  localparam int BIG       = 1 << 30;

  logic clk;
  logic rst;

  mbc_bus_sequencer_if bus ();

`ifdef MBC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  mbc_bus_sequencer #(
    .SYNC_STAGES (SYNC),
    .SETTLE      (SETTLE),
    .HOST_IDLE   (HOST_IDLE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MBC_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Reference model state (edge numbers of expected events).
  int we_edge  = -1;
  int busy_lo  = 1;
  int busy_hi  = 0;
  int gnt_on   = BIG;
  int gnt_off  = BIG;
  int last_hi  = 0;
  logic [1:0] exp_sel  = '0;
  logic [4:0] exp_data = '0;
  int exp_glitch = 0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_regs();
    check8("cfg_sel",  {6'b0, bus.cfg_sel},  {6'b0, exp_sel});
    check8("cfg_data", {3'b0, bus.cfg_data}, {3'b0, exp_data});
`ifdef MBC_GLITCH_CNT_EN
    check8("glitch_cnt", glitch_cnt, 8'(exp_glitch));
`endif
  endtask

  // One clock: advance, then compare per-cycle outputs on the falling edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check1("cfg_we",   bus.cfg_we,   edge_n == we_edge);
    check1("busy",     bus.busy,     (edge_n >= busy_lo) && (edge_n <= busy_hi));
    check1("host_gnt", bus.host_gnt, (edge_n >= gnt_on) && (edge_n < gnt_off));
  endtask

  // GB write of d raw cycles low; req_at raises host_req after that many cycles.
  task automatic gb_write(input logic [2:0] a, input logic [4:0] dt, input int d,
                          input int gap, input int req_at);
    int k;
    bit commit;
    bus.gb_addr    = a;
    bus.gb_data    = dt;
    bus.gb_write_n = 1'b0;
    k      = edge_n + 1;
    commit = (a[2] == 1'b0) && (d >= SETTLE + 1);
    if (commit) begin
      we_edge  = k + SYNC + SETTLE;
      exp_sel  = a[1:0];
      exp_data = dt;
      busy_hi  = imax(k + d + SYNC - 1, k + SYNC + SETTLE + 1);
    end else begin
      busy_hi = k + d + SYNC - 1;
      if (a[2] == 1'b0 && exp_glitch < 255) exp_glitch++;
    end
    busy_lo = k + SYNC;
    for (int i = 0; i < d; i++) begin
      if (i == req_at) bus.host_req = 1'b1;
      step();
    end
    bus.gb_write_n = 1'b1;
    last_hi = edge_n + 1;
    if (bus.host_req) begin
      gnt_on  = last_hi + SYNC + HOST_IDLE;
      gnt_off = BIG;
    end
    repeat (gap) step();
    while (edge_n <= busy_hi) step();
    check_regs();
  endtask

  task automatic drop_req();
    bus.host_req = 1'b0;
    gnt_off = edge_n + 1;
    step();
    gnt_on  = BIG;
    gnt_off = BIG;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst            = 1'b1;
    bus.gb_write_n = 1'b1;
    bus.gb_read_n  = 1'b1;
    bus.gb_addr    = '0;
    bus.gb_data    = '0;
    bus.host_req   = 1'b0;

    // Reset state
    repeat (3) step();
    check_regs();
    rst = 1'b0;
    last_hi = edge_n + 1 - SYNC;

    // ROM write, long enough to commit
    gb_write(3'b001, 5'h05, 10, 4, -1);
    // Short strobe: aborted
    gb_write(3'b010, 5'h1A, 2, 3, -1);
    // Boundary: one cycle short of commit, then exactly enough
    gb_write(3'b000, 5'h13, SETTLE, 2, -1);
    gb_write(3'b011, 5'h09, SETTLE + 1, 1, -1);
    // RAM-region write: busy but never commits
    gb_write(3'b101, 5'h11, 10, 3, -1);

    // Randomized transactions, host idle
    for (int t = 0; t < 40; t++) begin
      gb_write(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
               int'($urandom_range(1, 10)), int'($urandom_range(1, 6)), -1);
    end

    // Host grant after quiet bus, revoked by GB read, re-granted
    bus.host_req = 1'b1;
    gnt_on  = imax(last_hi + SYNC + HOST_IDLE, edge_n + 1);
    gnt_off = BIG;
    while (edge_n < gnt_on + 3) step();
    bus.gb_read_n = 1'b0;
    k = edge_n + 1;
    gnt_off = k + SYNC;
    repeat (3) step();
    bus.gb_read_n = 1'b1;
    last_hi = edge_n + 1;
    gnt_on  = last_hi + SYNC + HOST_IDLE;
    gnt_off = BIG;
    while (edge_n < gnt_on + 2) step();
    drop_req();

    // Host request and synced write arrive in IDLE together: write wins
    repeat (HOST_IDLE + 2) step();
    gb_write(3'b011, 5'h0C, 8, 4, SYNC);
    while (edge_n < gnt_on + 2) step();
    drop_req();

    // Reset while sampling a write, then a normal write
    bus.gb_addr    = 3'b010;
    bus.gb_data    = 5'h07;
    bus.gb_write_n = 1'b0;
    k = edge_n + 1;
    busy_lo = k + SYNC;
    busy_hi = BIG;
    repeat (SYNC + 1) step();
    rst = 1'b1;
    bus.gb_write_n = 1'b1;
    busy_hi = edge_n;
    repeat (2) step();
    rst = 1'b0;
    last_hi    = edge_n + 1 - SYNC;
    exp_sel    = '0;
    exp_data   = '0;
    exp_glitch = 0;
    check_regs();
    repeat (4) step();
    gb_write(3'b000, 5'h1F, 6, 3, -1);

`ifdef MBC_GLITCH_CNT_EN
    // Abort counter saturation
    for (int t = 0; t < 260; t++) begin
      gb_write(3'b001, 5'h02, 1, 1, -1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
